// File: rtl/sync_fifo_buffer_pkg.sv
// Shared UART buffering constants; instantiating blocks pass these as FIFO_DEPTH.
package sync_fifo_buffer_pkg;

    localparam int TX_FIFO_DEPTH = 32;
    localparam int RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/sync_fifo_buffer.sv
// Single-clock FIFO with first-word-fall-through (0-cycle) or registered (1-cycle) read.
// Writes while full and reads while empty are dropped; the flags let each side throttle.
module sync_fifo_buffer
    import sync_fifo_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = TX_FIFO_DEPTH,
    parameter int FWFT       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  write_i,
    input  logic                  read_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] head_dat;

    // The MSB is a wrap bit: equal indices with differing wrap bits mean full.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                      (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign wr_en    = write_i && !full_o;
    assign rd_en    = read_i && !empty_o;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; forced to zero so an empty FIFO never leaks stale data.
            assign rd_data_o = empty_o ? '0 : head_dat;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_en) begin
                    rd_data_d = head_dat;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data_o = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_buffer.sv
// Drives an FWFT instance and a registered-read instance with identical traffic against queue models.
module tb_sync_fifo_buffer;

    localparam int DA = 32;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr = 1'b0;
    logic       rd = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_full, a_empty, b_full, b_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(DA), .FWFT(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .write_i(wr), .read_i(rd),
        .rd_data_o(a_data), .full_o(a_full), .empty_o(a_empty)
    );

    sync_fifo_buffer #(.DATA_WIDTH(8), .FIFO_DEPTH(DB), .FWFT(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_data_i(wr_data), .write_i(wr), .read_i(rd),
        .rd_data_o(b_data), .full_o(b_full), .empty_o(b_empty)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain queues of accepted words; the registered-read output is the last word popped.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] exp_b = 8'h00;
    bit acc_wa, acc_ra, acc_wb, acc_rb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_b = 8'h00;
        end else begin
            acc_wa = wr && (qa.size() < DA);
            acc_ra = rd && (qa.size() > 0);
            acc_wb = wr && (qb.size() < DB);
            acc_rb = rd && (qb.size() > 0);
            if (acc_ra) void'(qa.pop_front());
            if (acc_wa) qa.push_back(wr_data);
            if (acc_rb) exp_b = qb.pop_front();
            if (acc_wb) qb.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_empty", 32'(a_empty), 32'(qa.size() == 0));
            chk("a_full", 32'(a_full), 32'(qa.size() == DA));
            chk("a_data", 32'(a_data), (qa.size() != 0) ? 32'(qa[0]) : 32'h0);
            chk("b_empty", 32'(b_empty), 32'(qb.size() == 0));
            chk("b_full", 32'(b_full), 32'(qb.size() == DB));
            chk("b_data", 32'(b_data), 32'(exp_b));
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr = w;
        rd = r;
        wr_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_a_empty", 32'(a_empty), 32'h1);
        chk("rst_a_full", 32'(a_full), 32'h0);
        chk("rst_a_data", 32'(a_data), 32'h0);
        chk("rst_b_empty", 32'(b_empty), 32'h1);
        chk("rst_b_full", 32'(b_full), 32'h0);
        chk("rst_b_data", 32'(b_data), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    bit rw, rr;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_a_empty", 32'(a_empty), 32'h1);
        chk("init_a_full", 32'(a_full), 32'h0);
        chk("init_a_data", 32'(a_data), 32'h0);
        chk("init_b_data", 32'(b_data), 32'h0);

        // FWFT ordering
        cyc(1'b1, 1'b0, 8'hA5);
        chk("fwft_first", 32'(a_data), 32'hA5);
        chk("fwft_nonempty", 32'(a_empty), 32'h0);
        cyc(1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b1, 8'h00);
        chk("fwft_second", 32'(a_data), 32'h3C);
        chk("std_first", 32'(b_data), 32'hA5);
        cyc(1'b0, 1'b1, 8'h00);
        chk("fwft_drained", 32'(a_empty), 32'h1);
        chk("fwft_zero", 32'(a_data), 32'h0);
        chk("std_second", 32'(b_data), 32'h3C);

        // Fill, overflow, drain
        for (int i = 0; i < DA; i++) cyc(1'b1, 1'b0, 8'(i));
        chk("fill_a_full", 32'(a_full), 32'h1);
        chk("fill_b_full", 32'(b_full), 32'h1);
        cyc(1'b1, 1'b0, 8'hFF);
        chk("ovf_a_full", 32'(a_full), 32'h1);
        for (int i = 0; i < DA; i++) begin
            chk("drain_seq", 32'(a_data), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
        end
        chk("drain_empty", 32'(a_empty), 32'h1);
        chk("std_hold_last", 32'(b_data), 32'h7);

        // Underflow and simultaneous operations
        cyc(1'b0, 1'b1, 8'h00);
        chk("udf_empty", 32'(a_empty), 32'h1);
        cyc(1'b1, 1'b1, 8'h11);
        chk("rw_empty_a", 32'(a_data), 32'h11);
        chk("rw_empty_flag", 32'(a_empty), 32'h0);
        chk("rw_empty_b", 32'(b_data), 32'h7);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b1, 8'h80);
        chk("rw_half_head", 32'(a_data), 32'h20);
        cyc(1'b1, 1'b1, 8'h81);
        chk("rw_half_head2", 32'(a_data), 32'h21);
        chk("rw_half_flags", 32'({a_full, a_empty}), 32'h0);
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 8'h00);
        chk("rw_half_drained", 32'(a_empty), 32'h1);

        // Wrap-around with five words in flight
        for (int i = 0; i < 3 * DA; i++) begin
            if (i >= 5) chk("wrap_seq", 32'(a_data), 32'(i - 5));
            cyc(1'b1, i >= 5, 8'(i));
        end
        for (int i = 3 * DA - 5; i < 3 * DA; i++) begin
            chk("wrap_tail", 32'(a_data), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
        end
        chk("wrap_empty", 32'(a_empty), 32'h1);

        // Registered-read mode
        do_reset();
        cyc(1'b1, 1'b0, 8'h5A);
        chk("std_before_read", 32'(b_data), 32'h0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("std_read", 32'(b_data), 32'h5A);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        chk("std_hold", 32'(b_data), 32'h5A);
        cyc(1'b1, 1'b0, 8'h6B);
        chk("std_hold_wr", 32'(b_data), 32'h5A);
        cyc(1'b0, 1'b1, 8'h00);
        chk("std_next", 32'(b_data), 32'h6B);

        // Random traffic with a reset in the middle
        for (int n = 0; n < 1600; n++) begin
            if (n == 800) do_reset();
            if (n < 400 || (n >= 800 && n < 1200)) begin
                rw = ($urandom_range(0, 99) < 70);
                rr = ($urandom_range(0, 99) < 35);
            end else begin
                rw = ($urandom_range(0, 99) < 35);
                rr = ($urandom_range(0, 99) < 70);
            end
            cyc(rw, rr, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
